// File: rtl/bram_if_ctrl_burst.sv
// Burst BRAM port controller: valid/ready commands, auto-incrementing address, read-latency-aligned return.
// Define BRAM_CTRL_RDREG_EN to register rdata_out/rdata_valid/rdata_last (read latency RD_LAT+1).
//   state  | meaning
//   IDLE   | waiting for a command, req_ready high
//   WBURST | write beats issued on each wdata_valid
//   RBURST | one read beat issued per cycle
module bram_if_ctrl_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 17,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16,
    localparam int LEN_W    = $clog2(MAX_BURST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic              rdata_last,
    output logic              busy,
    output logic              enb,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] wdata_out,
    input  logic [DATA_W-1:0] rdata_in
);

    typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_cur;
    logic [ADDR_W-1:0] addr_last;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] wdata_last;
    logic [RD_LAT-1:0] vpipe;
    logic [RD_LAT-1:0] lpipe;
    logic              beat;
    logic              last_beat;

    always_comb begin
        beat      = (state == RBURST) || (state == WBURST && wdata_valid);
        last_beat = (cnt == len_q);
    end

    assign req_ready   = (state == IDLE) && !rst;
    assign wdata_ready = (state == WBURST);
    assign enb         = beat;
    assign web         = (state == WBURST) && wdata_valid;
    // Outside a burst the port shows the last address/data actually driven.
    assign addrb       = (state == IDLE) ? addr_last : addr_cur;
    assign wdata_out   = (state == WBURST) ? wdata_in : wdata_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_cur   <= '0;
            addr_last  <= '0;
            len_q      <= '0;
            cnt        <= '0;
            wdata_last <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_cur <= req_addr;
                        len_q    <= req_len;
                        cnt      <= '0;
                        state    <= req_wr ? WBURST : RBURST;
                    end
                end
                WBURST, RBURST: begin
                    if (beat) begin
                        addr_cur  <= addr_cur + ADDR_W'(1);
                        addr_last <= addr_cur;
                        cnt       <= cnt + LEN_W'(1);
                        if (last_beat) state <= IDLE;
                    end
                    if (web) wdata_last <= wdata_in;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
            lpipe <= '0;
        end else begin
            vpipe[0] <= (state == RBURST);
            lpipe[0] <= (state == RBURST) && last_beat;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                lpipe[i] <= lpipe[i-1];
            end
        end
    end

`ifdef BRAM_CTRL_RDREG_EN
    logic              rv_q;
    logic              rl_q;
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rv_q <= 1'b0;
            rl_q <= 1'b0;
            rd_q <= '0;
        end else begin
            rv_q <= vpipe[RD_LAT-1];
            rl_q <= lpipe[RD_LAT-1];
            rd_q <= vpipe[RD_LAT-1] ? rdata_in : '0;
        end
    end

    assign rdata_valid = rv_q;
    assign rdata_last  = rl_q;
    assign rdata_out   = rd_q;
    assign busy        = (state != IDLE) || (|vpipe) || rv_q;
`else
    assign rdata_valid = vpipe[RD_LAT-1];
    assign rdata_last  = lpipe[RD_LAT-1];
    // Gated so the read bus idles at zero between beats and after reset.
    assign rdata_out   = rdata_valid ? rdata_in : '0;
    assign busy        = (state != IDLE) || (|vpipe);
`endif

endmodule

// File: tb/tb_bram_if_ctrl_burst.sv
// Directed bench for bram_if_ctrl_burst with a BRAM model and a read-return scoreboard.
module tb_bram_if_ctrl_burst;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 17;
    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 16;
    localparam int LEN_W     = $clog2(MAX_BURST);
`ifdef BRAM_CTRL_RDREG_EN
    localparam int LAT = RD_LAT + 1;
`else
    localparam int LAT = RD_LAT;
`endif

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wdata_in;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] rdata_out;
    logic              rdata_valid;
    logic              rdata_last;
    logic              busy;
    logic              enb;
    logic              web;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] wdata_out;
    logic [DATA_W-1:0] rdata_in;

    bram_if_ctrl_burst #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_in(wdata_in), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata_out(rdata_out), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
        .busy(busy), .enb(enb), .web(web), .addrb(addrb),
        .wdata_out(wdata_out), .rdata_in(rdata_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: registered read with RD_LAT stages, read-before-write.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] dpipe [RD_LAT];
    always @(posedge clk) begin
        if (enb && web) mem[addrb] <= wdata_out;
        if (enb && !web) dpipe[0] <= mem[addrb];
        for (int k = 1; k < RD_LAT; k++) dpipe[k] <= dpipe[k-1];
    end
    assign rdata_in = dpipe[RD_LAT-1];

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        int                due;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    int                errors = 0;
    int                checks = 0;
    int                cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard monitor runs once per cycle, then advances to just past the next edge.
    task automatic cycle();
        exp_t e;
        #1;
        if (rdata_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rd_data", 32'(rdata_out), 32'(e.data));
                check("rd_last", 32'(rdata_last), 32'(e.last));
                check("rd_cycle", cyc, e.due);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic accept(input logic wr, input logic [ADDR_W-1:0] a, input int len);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_len   = LEN_W'(len);
        settle();
        check("req_ready", 32'(req_ready), 32'd1);
        cycle();
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input int len,
                            input logic [DATA_W-1:0] base, input logic [7:0] pat);
        logic [ADDR_W-1:0] ea;
        logic              v;
        int                b;
        accept(1'b1, a, len);
        ea = a;
        b  = 0;
        for (int step = 0; step < 32 && b <= len; step++) begin
            v           = (step < 8) ? pat[step] : 1'b1;
            wdata_valid = v;
            wdata_in    = base + DATA_W'(b);
            settle();
            check("wr_ready", 32'(wdata_ready), 32'd1);
            check("wr_enb", 32'(enb), 32'(v));
            check("wr_web", 32'(web), 32'(v));
            check("wr_addr", 32'(addrb), 32'(ea));
            if (v) begin
                check("wr_data", 32'(wdata_out), 32'(base + DATA_W'(b)));
                ref_mem[ea] = base + DATA_W'(b);
                ea++;
                b++;
            end
            cycle();
        end
        wdata_valid = 1'b0;
        check("wr_beats", b, len + 1);
        settle();
        check("wr_req_ready_after", 32'(req_ready), 32'd1);
        check("wr_enb_after", 32'(enb), 32'd0);
        check("wr_busy_after", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < LAT + 4 && sb.size() > 0; k++) cycle();
        check("rd_drain", sb.size(), 0);
        settle();
        check("rd_busy_end", 32'(busy), 32'd0);
        check("rd_valid_end", 32'(rdata_valid), 32'd0);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int len);
        logic [ADDR_W-1:0] ea;
        accept(1'b0, a, len);
        ea = a;
        for (int i = 0; i <= len; i++) begin
            settle();
            check("rd_enb", 32'(enb), 32'd1);
            check("rd_web", 32'(web), 32'd0);
            check("rd_addr", 32'(addrb), 32'(ea));
            sb.push_back('{data: ref_mem[ea], last: (i == len), due: cyc + LAT});
            ea++;
            cycle();
        end
        settle();
        check("rd_req_ready_after", 32'(req_ready), 32'd1);
        check("rd_enb_after", 32'(enb), 32'd0);
        check("rd_busy_tail", 32'(busy), 32'd1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_wr      = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        wdata_in    = '0;
        wdata_valid = 1'b0;

        cycle();
        cycle();
        settle();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_rdata_last", 32'(rdata_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_enb", 32'(enb), 32'd0);
        check("rst_web", 32'(web), 32'd0);
        check("rst_addrb", 32'(addrb), 32'd0);
        check("rst_wdata_out", 32'(wdata_out), 32'd0);
        check("rst_rdata_out", 32'(rdata_out), 32'd0);
        rst = 1'b0;
        cycle();

        // single write then read
        do_write(17'h00010, 0, 8'hA5, 8'hFF);
        do_read(17'h00010, 0);

        // stalled write burst, pattern 1,0,0,1,1,0,1
        do_write(17'h00100, 3, 8'h11, 8'h59);
        do_read(17'h00100, 3);

        // full-length burst
        do_write(17'h00200, 15, 8'h00, 8'hFF);
        do_read(17'h00200, 15);

        // address wrap
        do_write(17'h1FFFE, 3, 8'h30, 8'hFF);
        do_read(17'h1FFFE, 3);

        // reset one cycle after the 3rd read beat
        accept(1'b0, 17'h00200, 7);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("rr_enb", 32'(enb), 32'd1);
            if (i + LAT <= 3)
                sb.push_back('{data: ref_mem[17'h00200 + 17'(i)], last: 1'b0, due: cyc + LAT});
            cycle();
        end
        rst = 1'b1;
        settle();
        check("rr_req_ready_in_rst", 32'(req_ready), 32'd0);
        cycle();
        rst = 1'b0;
        settle();
        check("rr_enb", 32'(enb), 32'd0);
        check("rr_web", 32'(web), 32'd0);
        check("rr_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rr_rdata_last", 32'(rdata_last), 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_addrb", 32'(addrb), 32'd0);
        check("rr_wdata_out", 32'(wdata_out), 32'd0);
        check("rr_rdata_out", 32'(rdata_out), 32'd0);
        check("rr_req_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            settle();
            check("rr_enb_quiet", 32'(enb), 32'd0);
            cycle();
        end
        check("rr_sb_empty", sb.size(), 0);

        // recovery after reset
        do_write(17'h00040, 1, 8'h5C, 8'hFF);
        do_read(17'h00040, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
